decode_stage_rf: RTL
====================

Name: decode_stage_rf

Overview:
Parametrised Y86-64 decode stage with its own D pipeline register and register file.
- The D register captures fetch outputs and supports stall and bubble.
- The register file is written from the W stage. It holds NREG registers; register ID 4'hF means "none".
- Combinational decode produces src/dst IDs and forwarded valA/valB for the E register.
- The block sits between fetch and the E pipeline register.

Parameters:
DATA_W, 64, width of register, valC and valP data
NREG, 15, number of architectural registers (IDs 0..NREG-1); must be ≤15
RSP_ID, 4, register ID used as the stack pointer

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
D_stall  in  1  hold D register contents
D_bubble  in  1  load NOP bubble into D register
f_stat  in  3  fetch status
f_icode, f_ifun  in  4 each  fetched instruction code/function
f_rA, f_rB  in  4 each  fetched register specifiers
f_valC, f_valP  in  DATA_W each  constant and incremented PC
e_dstE  in  4  forwarding destination ID
e_valE  in  DATA_W  forwarding value
M_dstE, M_dstM  in  4 each  forwarding destination IDs
M_valE, m_valM  in  DATA_W each  forwarding values
W_dstE, W_dstM  in  4 each  forwarding and write-back destination IDs
W_valE, W_valM  in  DATA_W each  forwarding and write-back values
d_stat  out  3  decode status
d_icode, d_ifun  out  4 each  decoded instruction code/function
d_valC  out  DATA_W  passed-through constant
d_valA, d_valB  out  DATA_W each  selected/forwarded operands
d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  register IDs

Behaviour:
- D register, on async rst:
  - stat = 3'h1 (AOK), icode = 4'h1 (NOP), ifun = 0
  - rA = rB = 4'hF, valC = valP = 0
- D register at posedge clk:
  - D_stall: hold current contents.
  - D_bubble without D_stall: load the reset/NOP values.
  - Both asserted: stall wins.
  - Otherwise: load the f_* inputs.
- Register file, on async rst: all NREG entries cleared to 0.
- Register file at posedge clk:
  - W_dstE ≠ F and < NREG: write W_valE.
  - Then W_dstM ≠ F and < NREG: write W_valM. If both target the same ID, W_valM wins.
  - IDs ≥ NREG other than F are ignored.
- d_icode, d_ifun, d_valC, d_stat: combinational pass-through of D register contents (D_icode, D_ifun, D_valC, D_stat).
- d_srcA:
  - icode 2, 4, 6, A → rA
  - icode 9, B → RSP_ID
  - otherwise → F
- d_srcB:
  - icode 4, 5, 6 → rB
  - icode 8, 9, A, B → RSP_ID
  - otherwise → F
- d_dstE:
  - icode 2, 3, 6 → rB
  - icode 8, 9, A, B → RSP_ID
  - otherwise → F
- d_dstM:
  - icode 5, B → rA
  - otherwise → F
- d_valA priority, first match wins:
  1. icode 7 or 8 → D_valP
  2. srcA = F → 0
  3. e_dstE → e_valE
  4. M_dstM → m_valM
  5. M_dstE → M_valE
  6. W_dstM → W_valM
  7. W_dstE → W_valE
  8. otherwise register file, read asynchronously
- d_valB: same chain from step 2 onward, without the valP step.
- Forwarding never matches ID F. An ID ≥ NREG with no forwarding match reads 0.
- A same-cycle W write is covered by W forwarding; no separate write-to-read bypass exists.
- No latches: every output is fully assigned on all paths.
- Decode latency: 0 cycles after the D register. The D register adds 1 cycle from the f_* inputs.
- Reset deasserted mid-stream: the first clock edge loads f_* normally.

Optional Feature:
Macro DECODE_HAZARD_EN.

With the macro defined:
- Extra inputs: E_icode (4 bits), E_dstM (4 bits).
- Extra output: d_loaduse (1 bit).
- d_loaduse = 1 when E_icode ∈ {5, B} and E_dstM ≠ F and E_dstM ∈ {d_srcA, d_srcB}.
- d_loaduse = 1 when any of D_icode, E_icode or M_icode equals 9 (ret), and M_icode is an additional 4-bit input.
- d_loaduse is combinational.
- The block does not itself stall; the external control unit uses d_loaduse.

Without the macro: these ports and that logic are absent.

Test Plan:
1. Reset → d_icode = 1, d_srcA = d_srcB = d_dstE = d_dstM = F, d_valA = d_valB = 0, d_stat = 1; read of any register returns 0.
2. W_dstE = 3, W_valE = 0x55 on one edge, then D = rrmovq rA = 3 (icode 2) → W_dstE set to F before the read: d_valA = 0x55 from the register file. With W_dstE still 3 and W_valE = 0x77: d_valA = 0x77 (forwarded).
3. D = addq rA = 1, rB = 2 (icode 6). Set e_dstE = 1 with e_valE = 0xA and M_dstE = 1 with M_valE = 0xB, plus W_dstM = 2 with W_valM = 0xC → d_valA = 0xA (e wins), d_valB = 0xC, d_dstE = 2.
4. D = call (icode 8) with valP = 0x40, e_dstE = 4 → d_valA = 0x40 (valP beats forwarding), d_srcB = 4, d_dstE = 4.
5. f = irmovq sequence. Assert D_stall for 2 cycles → D held. Assert D_stall and D_bubble together → D held. Assert D_bubble alone → d_icode = 1, d_dstE = F.
6. W_dstE = 4 with W_valE = 1 and W_dstM = 4 with W_valM = 2 on the same edge, then D = popq-style read of register 4 with no forwarding → reads 2. With DECODE_HAZARD_EN: E_icode = 5, E_dstM = d_srcA = 3 → d_loaduse = 1.

Source files
------------

// File: rtl/decode_stage_rf_if.sv
// Signal bundle between fetch/forwarding/pipeline control (master) and decode_stage_rf (slave).
// Optional hazard signals E_icode, E_dstM, M_icode, d_loaduse exist only with DECODE_HAZARD_EN.
interface decode_stage_rf_if #(
    parameter int DATA_W = 64
);
    logic              D_stall;
    logic              D_bubble;
    logic [2:0]        f_stat;
    logic [3:0]        f_icode;
    logic [3:0]        f_ifun;
    logic [3:0]        f_rA;
    logic [3:0]        f_rB;
    logic [DATA_W-1:0] f_valC;
    logic [DATA_W-1:0] f_valP;
    logic [3:0]        e_dstE;
    logic [DATA_W-1:0] e_valE;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] m_valM;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [2:0]        d_stat;
    logic [3:0]        d_icode;
    logic [3:0]        d_ifun;
    logic [DATA_W-1:0] d_valC;
    logic [DATA_W-1:0] d_valA;
    logic [DATA_W-1:0] d_valB;
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [3:0]        d_dstE;
    logic [3:0]        d_dstM;
`ifdef DECODE_HAZARD_EN
    logic [3:0]        E_icode;
    logic [3:0]        E_dstM;
    logic [3:0]        M_icode;
    logic              d_loaduse;
`endif

    modport master (
`ifdef DECODE_HAZARD_EN
        output E_icode, E_dstM, M_icode,
        input  d_loaduse,
`endif
        output D_stall, D_bubble,
        output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        output e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        output W_dstE, W_dstM, W_valE, W_valM,
        input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
        input  d_srcA, d_srcB, d_dstE, d_dstM
    );

    modport slave (
`ifdef DECODE_HAZARD_EN
        input  E_icode, E_dstM, M_icode,
        output d_loaduse,
`endif
        input  D_stall, D_bubble,
        input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        input  e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        input  W_dstE, W_dstM, W_valE, W_valM,
        output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
        output d_srcA, d_srcB, d_dstE, d_dstM
    );
endinterface

// File: rtl/decode_stage_rf.sv
// Y86-64 decode stage: D pipeline register, NREG-entry register file (NREG <= 15), operand forwarding.
// Define DECODE_HAZARD_EN to add the combinational d_loaduse load-use / ret hazard flag.
module decode_stage_rf #(
    parameter int         DATA_W = 64,
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = 4'h4
) (
    input logic              clk,
    input logic              rst,
    decode_stage_rf_if.slave bus
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] NREG_ID  = 4'(NREG);
    localparam int         IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int         FWD_N    = 5;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        rA;
        logic [3:0]        rB;
        logic [DATA_W-1:0] valC;
        logic [DATA_W-1:0] valP;
    } dreg_t;

    localparam dreg_t DREG_NOP = '{
        stat:  3'h1,
        icode: I_NOP,
        ifun:  4'h0,
        rA:    REG_NONE,
        rB:    REG_NONE,
        valC:  '0,
        valP:  '0
    };

    function automatic logic in_rf(input logic [3:0] id);
        return (id != REG_NONE) && (id < NREG_ID);
    endfunction

    dreg_t dreg_q, dreg_d;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        dreg_d = dreg_q;
        if (!bus.D_stall) begin
            if (bus.D_bubble) begin
                dreg_d = DREG_NOP;
            end else begin
                dreg_d.stat  = bus.f_stat;
                dreg_d.icode = bus.f_icode;
                dreg_d.ifun  = bus.f_ifun;
                dreg_d.rA    = bus.f_rA;
                dreg_d.rB    = bus.f_rB;
                dreg_d.valC  = bus.f_valC;
                dreg_d.valP  = bus.f_valP;
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking '<=' so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dreg_q <= DREG_NOP;
        end else begin
            dreg_q <= dreg_d;
        end
    end

    logic [DATA_W-1:0] rf_q [NREG];

    // NOTE: the register file has an async clear, so it maps to flops rather than a RAM macro.
    // The W_dstM write comes second so it overrides W_dstE on a shared ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (in_rf(bus.W_dstE)) begin
                rf_q[bus.W_dstE[IDX_W-1:0]] <= bus.W_valE;
            end
            if (in_rf(bus.W_dstM)) begin
                rf_q[bus.W_dstM[IDX_W-1:0]] <= bus.W_valM;
            end
        end
    end

    logic [3:0] src_a, src_b, dst_e, dst_m;

    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (dreg_q.icode)
            I_RRMOVQ: begin
                src_a = dreg_q.rA;
                dst_e = dreg_q.rB;
            end
            I_IRMOVQ: begin
                dst_e = dreg_q.rB;
            end
            I_RMMOVQ: begin
                src_a = dreg_q.rA;
                src_b = dreg_q.rB;
            end
            I_MRMOVQ: begin
                src_b = dreg_q.rB;
                dst_m = dreg_q.rA;
            end
            I_OPQ: begin
                src_a = dreg_q.rA;
                src_b = dreg_q.rB;
                dst_e = dreg_q.rB;
            end
            I_CALL: begin
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            I_RET: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            I_PUSHQ: begin
                src_a = dreg_q.rA;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            I_POPQ: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
                dst_m = dreg_q.rA;
            end
            default: begin
            end
        endcase
    end

    // Forwarding sources, index 0 = highest priority.
    logic [3:0]        fwd_id  [FWD_N];
    logic [DATA_W-1:0] fwd_val [FWD_N];

    always_comb begin
        fwd_id[0]  = bus.e_dstE;
        fwd_val[0] = bus.e_valE;
        fwd_id[1]  = bus.M_dstM;
        fwd_val[1] = bus.m_valM;
        fwd_id[2]  = bus.M_dstE;
        fwd_val[2] = bus.M_valE;
        fwd_id[3]  = bus.W_dstM;
        fwd_val[3] = bus.W_valM;
        fwd_id[4]  = bus.W_dstE;
        fwd_val[4] = bus.W_valE;
    end

    logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;

    assign rf_a = in_rf(src_a) ? rf_q[src_a[IDX_W-1:0]] : '0;
    assign rf_b = in_rf(src_b) ? rf_q[src_b[IDX_W-1:0]] : '0;

    // Scanning from lowest to highest priority lets the last match win.
    always_comb begin
        val_a = rf_a;
        for (int k = FWD_N - 1; k >= 0; k--) begin
            if (fwd_id[k] == src_a) begin
                val_a = fwd_val[k];
            end
        end
        if (src_a == REG_NONE) begin
            val_a = '0;
        end
        if ((dreg_q.icode == I_CALL) || (dreg_q.icode == I_JXX)) begin
            val_a = dreg_q.valP;
        end
    end

    always_comb begin
        val_b = rf_b;
        for (int k = FWD_N - 1; k >= 0; k--) begin
            if (fwd_id[k] == src_b) begin
                val_b = fwd_val[k];
            end
        end
        if (src_b == REG_NONE) begin
            val_b = '0;
        end
    end

    assign bus.d_stat  = dreg_q.stat;
    assign bus.d_icode = dreg_q.icode;
    assign bus.d_ifun  = dreg_q.ifun;
    assign bus.d_valC  = dreg_q.valC;
    assign bus.d_valA  = val_a;
    assign bus.d_valB  = val_b;
    assign bus.d_srcA  = src_a;
    assign bus.d_srcB  = src_b;
    assign bus.d_dstE  = dst_e;
    assign bus.d_dstM  = dst_m;

`ifdef DECODE_HAZARD_EN
    logic e_is_load, load_use, ret_in_flight;

    assign e_is_load     = (bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ);
    assign load_use      = e_is_load && (bus.E_dstM != REG_NONE) &&
                           ((bus.E_dstM == src_a) || (bus.E_dstM == src_b));
    assign ret_in_flight = (dreg_q.icode == I_RET) || (bus.E_icode == I_RET) ||
                           (bus.M_icode == I_RET);
    assign bus.d_loaduse = load_use || ret_in_flight;
`endif

endmodule
